module_keypad_scanner: RTL and testbench

Input-side counterpart of the 7-segment display path: scans a 4x4 hexadecimal matrix keypad by driving columns and reading rows. Each debounced key press becomes a 4-bit hex code and is shifted into a 16-bit entry register. The register's `data_out` drives `hex0`..`hex3` of the display controller, replacing the LFSR/PIPO source. Runs in the 10 MHz clock domain.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/module_sync_2ff.sv | 25 ++
 rtl/module_keypad_scanner.sv | 123 ++++++++++++
 tb/tb_module_keypad_scanner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  // Hex code per key, indexed {row, col}; entry 0 is r0/c0 ('1').
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,   // r3: c3..c0
    4'hC, 4'h9, 4'h8, 4'h7,   // r2
    4'hB, 4'h6, 4'h5, 4'h4,   // r1
    4'hA, 4'h3, 4'h2, 4'h1    // r0
  };

  // Active-low column drive, one bit low per column index.
  localparam logic [3:0][3:0] COL_ONECOLD = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Index of the lowest-numbered low row; callers guarantee at least one is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!rows[i]) lowest_low = 2'(i);
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    key_lookup = KEYMAP[{row, col}];
  endfunction

endpackage

// File: rtl/module_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
module module_sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Capture into the metastability flop, then hand to the output flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, hex entry shift register.
// data_out feeds hex0..hex3 of the 7-segment display controller.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 10000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] data_out
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt;
  logic             sample;
  state_t           state;
  logic [1:0]       col_idx;
  logic [1:0]       col_nxt;
  logic [1:0]       cand_row;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cand_high;
  logic [3:0]       code;

  module_sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  // The sample point is the last divider count, so a newly driven column
  // has had a full period to settle through the synchronizer.
  assign sample    = (div_cnt == DIV_LAST);
  assign col_nxt   = col_idx + 2'd1;
  assign cnt_inc   = deb_cnt + CNT_W'(1);
  assign cand_high = row_s[cand_row];
  assign code      = key_lookup(cand_row, col_idx);

  // Free-running scan divider, 0..SCAN_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_cnt <= '0;
    else if (sample) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  // Scan / debounce / accept / release-debounce state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_out   <= COL_ONECOLD[0];
      cand_row  <= 2'd0;
      deb_cnt   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      data_out  <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: if (sample) begin
          if (row_s == 4'hF) begin
            col_idx <= col_nxt;
            col_out <= COL_ONECOLD[col_nxt];
          end else begin
            // Column freezes here; only the latched column stays driven.
            cand_row <= lowest_low(row_s);
            deb_cnt  <= CNT_W'(1);
            state    <= (DEBOUNCE_CNT == 1) ? PRESSED : DEBOUNCE;
          end
        end
        DEBOUNCE: if (sample) begin
          if (!cand_high) begin
            deb_cnt <= cnt_inc;
            if (cnt_inc == CNT_DONE) state <= PRESSED;
          end else begin
            deb_cnt <= '0;
            col_idx <= col_nxt;
            col_out <= COL_ONECOLD[col_nxt];
            state   <= SCAN;
          end
        end
        PRESSED: begin
          key_valid <= 1'b1;
          key_code  <= code;
          data_out  <= {data_out[11:0], code};
          key_held  <= 1'b1;
          deb_cnt   <= '0;
          state     <= RELEASE;
        end
        RELEASE: if (sample) begin
          if (cand_high) begin
            deb_cnt <= cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              key_held <= 1'b0;
              deb_cnt  <= '0;
              col_idx  <= col_nxt;
              col_out  <= COL_ONECOLD[col_nxt];
              state    <= SCAN;
            end
          end else begin
            // Any bounce back low restarts the release count.
            deb_cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Directed bench for module_keypad_scanner with a behavioural keypad matrix.
module tb_module_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held;
  logic [15:0] data_out;
  logic [15:0] keys;   // bit r*4+c set = key (r,c) pressed
  int          checks = 0, failures = 0, vcount = 0;

  module_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Running count of accept pulses outside reset.
  always @(posedge clk) if (!rst && key_valid) vcount <= vcount + 1;

  task automatic do_reset();
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (key_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_held_low(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!key_held) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [3:0] oc [4];
    logic [3:0] exp_col;
    oc[0] = 4'b1110; oc[1] = 4'b1101; oc[2] = 4'b1011; oc[3] = 4'b0111;
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
    checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL rst_col: got %b expected 1110", col_out); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL rst_code: got %h expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rst_held: got %b expected 0", key_held); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL rst_data: got %h expected 0000", data_out); end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_col = oc[(k / 4) % 4];
      checks++;
      if (col_out !== exp_col) begin
        failures++; $display("FAIL scan_col cycle %0d: got %b expected %b", k, col_out, exp_col);
      end
    end
    checks++; if (vcount !== 0) begin failures++; $display("FAIL idle_valid: got %0d pulses expected 0", vcount); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL idle_data: got %h expected 0000", data_out); end
  endtask

  task automatic test_press_5();
    bit got;
    int v0;
    do_reset();
    v0 = vcount;
    keys[5] = 1'b1;
    wait_valid(200, got);
    checks++; if (!got) begin failures++; $display("FAIL p5_timeout: got no key_valid expected pulse"); end
    checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL p5_code: got %h expected 5", key_code); end
    checks++; if (data_out !== 16'h0005) begin failures++; $display("FAIL p5_data: got %h expected 0005", data_out); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL p5_held: got %b expected 1", key_held); end
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL p5_pulse_width: got %b expected 0", key_valid); end
    repeat (40) @(negedge clk);
    checks++; if (col_out !== 4'b1101) begin failures++; $display("FAIL p5_col_hold: got %b expected 1101", col_out); end
    checks++; if (vcount - v0 !== 1) begin failures++; $display("FAIL p5_one_pulse: got %0d expected 1", vcount - v0); end
    keys = '0;
    wait_held_low(40, got);
    checks++; if (!got) begin failures++; $display("FAIL p5_release: got held=1 expected 0"); end
    checks++; if (col_out !== 4'b1011) begin failures++; $display("FAIL p5_resume: got %b expected 1011", col_out); end
  endtask

  task automatic enter_key(input int idx, input logic [3:0] exp_code, input logic [15:0] exp_data);
    bit got;
    keys = '0;
    keys[idx] = 1'b1;
    wait_valid(200, got);
    checks++; if (!got) begin failures++; $display("FAIL seq_timeout key %h: got no key_valid expected pulse", exp_code); end
    checks++; if (key_code !== exp_code) begin failures++; $display("FAIL seq_code: got %h expected %h", key_code, exp_code); end
    checks++; if (data_out !== exp_data) begin failures++; $display("FAIL seq_data: got %h expected %h", data_out, exp_data); end
    keys = '0;
    wait_held_low(40, got);
    checks++; if (!got) begin failures++; $display("FAIL seq_release key %h: got held=1 expected 0", exp_code); end
  endtask

  task automatic test_sequence();
    do_reset();
    enter_key(0,  4'h1, 16'h0001);
    enter_key(3,  4'hA, 16'h001A);
    enter_key(12, 4'h0, 16'h01A0);
    enter_key(13, 4'hF, 16'h1A0F);
    enter_key(8,  4'h7, 16'hA0F7);
  endtask

  // Key 9 low for exactly two sample points after column 2 is driven.
  task automatic test_glitch();
    int v0;
    bit seen_next;
    keys = '0;
    v0 = vcount;
    for (int i = 0; i < 40 && col_out == 4'b1011; i++) @(negedge clk);
    for (int i = 0; i < 40 && col_out != 4'b1011; i++) @(negedge clk);
    checks++; if (col_out !== 4'b1011) begin failures++; $display("FAIL gl_align: got %b expected 1011", col_out); end
    keys[10] = 1'b1;
    repeat (8) @(negedge clk);
    keys = '0;
    seen_next = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_out == 4'b0111) seen_next = 1'b1;
    end
    checks++; if (vcount !== v0) begin failures++; $display("FAIL gl_valid: got %0d pulses expected 0", vcount - v0); end
    checks++; if (data_out !== 16'hA0F7) begin failures++; $display("FAIL gl_data: got %h expected A0F7", data_out); end
    checks++; if (!seen_next) begin failures++; $display("FAIL gl_rescan: got no column 3 drive expected 0111"); end
  endtask

  // Key B held 50 samples, then release with pattern high,low,high,high,high.
  task automatic test_bounce();
    bit got;
    int v0;
    keys = '0;
    v0 = vcount;
    keys[7] = 1'b1;
    wait_valid(200, got);
    checks++; if (!got) begin failures++; $display("FAIL bn_timeout: got no key_valid expected pulse"); end
    checks++; if (key_code !== 4'hB) begin failures++; $display("FAIL bn_code: got %h expected B", key_code); end
    checks++; if (data_out !== 16'h0F7B) begin failures++; $display("FAIL bn_data: got %h expected 0F7B", data_out); end
    repeat (3) @(negedge clk);        // just past a sample point
    repeat (4 * 48) @(negedge clk);
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL bn_hold: got %b expected 1", key_held); end
    keys = '0;     repeat (4) @(negedge clk);
    keys[7] = 1'b1; repeat (4) @(negedge clk);
    keys = '0;     repeat (4) @(negedge clk);
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL bn_held_1high: got %b expected 1", key_held); end
    repeat (4) @(negedge clk);
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL bn_held_2high: got %b expected 1", key_held); end
    repeat (4) @(negedge clk);
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL bn_held_3high: got %b expected 0", key_held); end
    checks++; if (vcount - v0 !== 1) begin failures++; $display("FAIL bn_one_pulse: got %0d expected 1", vcount - v0); end
  endtask

  // Keys 2 and 8 together, then reset while the key is still held.
  task automatic test_multi_reset();
    bit got;
    int v0;
    keys = '0;
    keys[1] = 1'b1;
    keys[9] = 1'b1;
    wait_valid(200, got);
    checks++; if (!got) begin failures++; $display("FAIL mk_timeout: got no key_valid expected pulse"); end
    checks++; if (key_code !== 4'h2) begin failures++; $display("FAIL mk_code: got %h expected 2", key_code); end
    checks++; if (data_out !== 16'hF7B2) begin failures++; $display("FAIL mk_data: got %h expected F7B2", data_out); end
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL mr_col: got %b expected 1110", col_out); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL mr_code: got %h expected 0", key_code); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL mr_held: got %b expected 0", key_held); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL mr_data: got %h expected 0000", data_out); end
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v0 = vcount;
    @(negedge clk);
    checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL mr_col_after: got %b expected 1110", col_out); end
    repeat (30) @(negedge clk);
    checks++; if (vcount !== v0) begin failures++; $display("FAIL mr_no_pulse: got %0d pulses expected 0", vcount - v0); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL mr_data_after: got %h expected 0000", data_out); end
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    test_reset();
    test_press_5();
    test_sequence();
    test_glitch();
    test_bounce();
    test_multi_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
